param_sync_fifo: RTL and testbench
==================================

// Module: param_sync_fifo
// PURPOSE
//   Parametrised single-clock FIFO with valid/ready on both sides.
//   Storage is an unpacked register array (reg [WIDTH-1:0] mem [DEPTH-1:0]).
//   Reports occupancy, an almost-full flag, a high-water mark and read-side parity.
//   Generalises the fixed 8x32 array storage to arbitrary width and depth.
//   Adds flow control and status.
//   It is the standard buffering element for the vlog simulation test designs.
// PARAMETERS
//   WIDTH      8    data word width in bits, >= 1
//   DEPTH      32   number of entries; power of two, >= 2
//   AF_LEVEL   28   almost_full asserts when level >= AF_LEVEL; 1..DEPTH
//   AW         $clog2(DEPTH)  localparam, pointer index width
// PORTS
//   clk          in   1        single clock, all state updates on posedge
//   rst_n        in   1        synchronous reset, active-low
//   flush        in   1        synchronous clear of pointers/level/hwm
//   wr_valid     in   1        write request
//   wr_ready     out  1        FIFO can accept a word this cycle
//   wr_data      in   WIDTH    write data
//   rd_valid     out  1        rd_data holds the oldest word
//   rd_ready     in   1        consumer accepts rd_data this cycle
//   rd_data      out  WIDTH    oldest word (first-word fall-through)
//   rd_parity    out  1        ^rd_data (even-parity bit of the output word)
//   level        out  AW+1     current number of stored words, 0..DEPTH
//   almost_full  out  1        level >= AF_LEVEL
//   hwm          out  AW+1     maximum level reached since reset/flush
// BEHAVIOUR
//   - Clock and reset
//     - One clock: clk.
//     - Reset: rst_n, synchronous, active-low.
//     - Sampled only on posedge clk; it is not in any sensitivity list.
//   - Reset values
//     - wr_ptr, rd_ptr, level and hwm are 0.
//     - Hence wr_ready=1, rd_valid=0, almost_full=0.
//     - mem contents are not reset; rd_data is don't-care while rd_valid=0.
//   - Pointers
//     - wr_ptr and rd_ptr are AW+1 bits.
//     - The array is indexed with [AW-1:0]; pointers wrap naturally mod 2*DEPTH.
//     - empty = (wr_ptr == rd_ptr).
//     - full  = (index bits equal) && (MSBs differ).
//   - Handshake outputs
//     - wr_ready = !full. It is combinational from state only.
//     - wr_ready never depends on rd_ready: no write-through when full.
//     - rd_valid = !empty.
//   - Transfers
//     - push = wr_valid && wr_ready.
//     - pop  = rd_valid && rd_ready.
//   - Push: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr + 1.
//   - Pop: rd_ptr <= rd_ptr + 1.
//   - Latency
//     - A word pushed at edge N is visible on rd_data with rd_valid=1 after edge N.
//     - Write-to-read latency is 1 cycle.
//     - Empty-FIFO push+pop in the same cycle: only the push occurs (rd_valid was 0).
//   - level update
//     - push only: +1.
//     - pop only: -1.
//     - Both or neither: unchanged.
//     - level always equals wr_ptr - rd_ptr.
//   - hwm
//     - If the next level > hwm, then hwm <= next level.
//     - It saturates at DEPTH.
//   - Priority: rst_n=0 > flush=1 > push/pop.
//     - flush zeroes pointers, level and hwm.
//     - Any push or pop in the flush cycle is discarded.
//   - Mid-operation reset or flush
//     - The FIFO is empty on the following cycle.
//     - Stale mem words are never presented (rd_valid=0).
//   - Combinational outputs
//     - rd_data = mem[rd_ptr[AW-1:0]], combinational.
//     - rd_parity = ^rd_data, combinational.
// TESTING
//   1. Reset then idle -> level=0, rd_valid=0, wr_ready=1, hwm=0.
//   2. Push 8'h01..8'h20 (32 words) with rd_ready=0
//      -> level=32, wr_ready=0, almost_full=1 from 28th word, hwm=32.
//      A 33rd wr_valid is ignored.
//   3. From full, drain with rd_ready=1
//      -> rd_data 8'h01..8'h20 in order.
//      rd_parity=1 for 8'h01, 0 for 8'h03.
//      level reaches 0; hwm stays 32.
//   4. Level 5, wr_valid=rd_ready=1 for 100 cycles
//      -> level stays 5, pointers wrap past 64, data order preserved.
//   5. Empty FIFO, wr_valid=rd_ready=1 with 8'hA5
//      -> no pop that cycle; next cycle rd_valid=1, rd_data=8'hA5.
//   6. Level 10, assert flush together with push
//      -> next cycle level=0, hwm=0, rd_valid=0.
//      Repeat with rst_n=0 mid-burst -> same result.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with valid/ready on both sides, first-word
// fall-through read, and level / almost-full / high-water-mark status.
module param_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = 28
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_parity,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     hwm
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] AF_THRESH = (AW+1)'(AF_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      level_next;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  // Pointers carry one extra lap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign wr_ready    = !full;
  assign rd_valid    = !empty;
  assign push        = wr_valid && wr_ready;
  assign pop         = rd_valid && rd_ready;
  assign almost_full = (level >= AF_THRESH);

  assign rd_data   = mem[rd_ptr[AW-1:0]];
  assign rd_parity = ^rd_data;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    level_next = level;
    unique case ({push, pop})
      2'b10:   level_next = level + PTR_ONE;
      2'b01:   level_next = level - PTR_ONE;
      default: level_next = level;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      hwm    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      hwm    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      level <= level_next;
      if (level_next > hwm) hwm <= level_next;
    end
  end

  // NOTE: storage is deliberately not reset; rd_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo at its default 8x32 size.
module tb_param_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic             rd_parity;
  logic [AW:0]      level;
  logic             almost_full;
  logic [AW:0]      hwm;

  int checks = 0;
  int errors = 0;

  param_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(28)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_parity  (rd_parity),
    .level      (level),
    .almost_full(almost_full),
    .hwm        (hwm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_rd;
    logic [7:0] byte_v;

    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset then idle
    check("rst_level",    level,       0);
    check("rst_rd_valid", rd_valid,    0);
    check("rst_wr_ready", wr_ready,    1);
    check("rst_hwm",      hwm,         0);
    check("rst_af",       almost_full, 0);

    // Fill to full with rd_ready low
    for (int i = 1; i <= 32; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      check("fill_wr_ready", wr_ready, 1);
      tick();
      check("fill_level", level, i);
      check("fill_af",    almost_full, (i >= 28) ? 1 : 0);
    end
    check("full_wr_ready", wr_ready, 0);
    check("full_hwm",      hwm,      32);
    check("full_rd_valid", rd_valid, 1);
    check("full_head",     rd_data,  8'h01);
    check("parity_01",     rd_parity, 1);

    // 33rd write must be ignored
    wr_data = 8'hFF;
    tick();
    wr_valid = 1'b0;
    check("ovf_level", level,   32);
    check("ovf_head",  rd_data, 8'h01);

    // Drain in order
    rd_ready = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      byte_v = 8'(i);
      check("drain_valid",  rd_valid,  1);
      check("drain_data",   rd_data,   byte_v);
      check("drain_parity", rd_parity, ^byte_v);
      if (i == 3) check("parity_03", rd_parity, 0);
      tick();
    end
    rd_ready = 1'b0;
    check("drained_level", level,    0);
    check("drained_valid", rd_valid, 0);
    check("drained_hwm",   hwm,      32);
    check("drained_af",    almost_full, 0);

    // Level 5 then streaming push+pop for 100 cycles (pointers wrap)
    wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'h40 + i);
      tick();
    end
    check("stream_pre_level", level, 5);
    exp_rd = 8'h40;
    rd_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_data = 8'(8'h45 + i);
      check("stream_data", rd_data, exp_rd);
      tick();
      exp_rd = exp_rd + 8'd1;
      check("stream_level", level, 5);
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stream_tail", rd_data, exp_rd);
      tick();
      exp_rd = exp_rd + 8'd1;
    end
    rd_ready = 1'b0;
    check("stream_empty", rd_valid, 0);
    check("stream_hwm",   hwm,      32);

    // Push+pop on empty FIFO: only the push happens
    wr_valid = 1'b1; rd_ready = 1'b1; wr_data = 8'hA5;
    check("ft_pre_valid", rd_valid, 0);
    tick();
    wr_valid = 1'b0; rd_ready = 1'b0;
    check("ft_level", level,    1);
    check("ft_valid", rd_valid, 1);
    check("ft_data",  rd_data,  8'hA5);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("ft_drain", level, 0);

    // Level 10 then flush alongside push and pop
    wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'(8'h80 + i);
      tick();
    end
    check("fl_pre_level", level, 10);
    flush = 1'b1; rd_ready = 1'b1; wr_data = 8'h77;
    tick();
    flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    check("fl_level",    level,    0);
    check("fl_hwm",      hwm,      0);
    check("fl_rd_valid", rd_valid, 0);
    check("fl_wr_ready", wr_ready, 1);

    // Refill to 10: hwm restarts from 0 after flush
    wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'(8'hC0 + i);
      tick();
    end
    check("rf_level", level,   10);
    check("rf_hwm",   hwm,     10);
    check("rf_head",  rd_data, 8'hC0);

    // Reset mid-burst with push still requested
    rst_n = 1'b0; wr_data = 8'h33;
    tick();
    rst_n = 1'b1; wr_valid = 1'b0;
    check("mr_level",    level,    0);
    check("mr_hwm",      hwm,      0);
    check("mr_rd_valid", rd_valid, 0);
    check("mr_wr_ready", wr_ready, 1);
    tick();
    check("mr_idle_level", level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
